// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: D-stage stall, E-stage bubble, D-stage forward selects, MDU busy counter.
// Latency: Stall/FlushE/Fwd*/MDBusy are combinational; shadow scoreboard and busy counter advance once per CLK edge.
// Backpressure: Stall holds PC and D while FlushE inserts a bubble into E; M/W always advance.
// Optional: define HAZARD_STALL_CNT_EN to add the 32-bit StallCount output.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [4:0]       A1_D,
   input  logic [4:0]       A2_D,
   input  logic [1:0]       TuseRS_D,
   input  logic [1:0]       TuseRT_D,
   input  logic [4:0]       A3_D,
   input  logic             WE_D,
   input  logic [1:0]       Tnew_D,
   input  logic             MD_D,
   input  logic [1:0]       MDStart_D,
   output logic             Stall,
   output logic             FlushE,
   output logic [1:0]       FwdRS_D,
   output logic [1:0]       FwdRT_D,
   output logic             MDBusy
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]      StallCount
`endif
);

   localparam logic [1:0]       MDS_NONE = 2'b00;
   localparam logic [1:0]       MDS_MULT = 2'b01;
   localparam logic [1:0]       MDS_DIV  = 2'b10;
   localparam logic [1:0]       TUSE_NA  = 2'd3;
   localparam logic [1:0]       FWD_RF   = 2'b00;
   localparam logic [1:0]       FWD_E    = 2'b01;
   localparam logic [1:0]       FWD_M    = 2'b10;
   localparam logic [CNT_W-1:0] MULT_LD  = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV_CYCLES);

   // Shadow copies of the pipeline destination fields. The W entry is not
   // kept: the register file's write-first bypass covers it and nothing here
   // would ever read it.
   logic [4:0]       e_a3_q,   e_a3_d;
   logic             e_we_q,   e_we_d;
   logic [1:0]       e_tnew_q, e_tnew_d;
   logic [1:0]       e_mds_q,  e_mds_d;
   logic [4:0]       m_a3_q,   m_a3_d;
   logic             m_we_q,   m_we_d;
   logic [1:0]       m_tnew_q, m_tnew_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
   logic stall_rs, stall_rt, stall_md;

   // An entry can only supply rX if it writes, targets rX, and rX is not $0.
   function automatic logic entry_hit(input logic [4:0] a3, input logic we, input logic [4:0] rx);
      return we && (a3 != 5'd0) && (a3 == rx);
   endfunction

   // Combinational hazard detection and forward selection from current D inputs and shadow state.
   always_comb begin
      hit_e_rs = entry_hit(e_a3_q, e_we_q, A1_D);
      hit_e_rt = entry_hit(e_a3_q, e_we_q, A2_D);
      hit_m_rs = entry_hit(m_a3_q, m_we_q, A1_D);
      hit_m_rt = entry_hit(m_a3_q, m_we_q, A2_D);

      stall_rs = (TuseRS_D != TUSE_NA) &&
                 ((hit_e_rs && (e_tnew_q > TuseRS_D)) || (hit_m_rs && (m_tnew_q > TuseRS_D)));
      stall_rt = (TuseRT_D != TUSE_NA) &&
                 ((hit_e_rt && (e_tnew_q > TuseRT_D)) || (hit_m_rt && (m_tnew_q > TuseRT_D)));

      // Busy also covers the cycle the mult/div sits in E, before the counter loads.
      MDBusy   = (cnt_q != '0) || (e_mds_q != MDS_NONE);
      stall_md = MD_D && MDBusy;

      Stall    = stall_rs || stall_rt || stall_md;
      FlushE   = Stall;

      // E wins over M: it holds the newer value of the same register.
      FwdRS_D = FWD_RF;
      if (hit_e_rs && (e_tnew_q == 2'd0))
         FwdRS_D = FWD_E;
      else if (hit_m_rs && (m_tnew_q == 2'd0))
         FwdRS_D = FWD_M;

      FwdRT_D = FWD_RF;
      if (hit_e_rt && (e_tnew_q == 2'd0))
         FwdRT_D = FWD_E;
      else if (hit_m_rt && (m_tnew_q == 2'd0))
         FwdRT_D = FWD_M;
   end

   // Next-state for the shadow scoreboard and the MDU busy counter.
   always_comb begin
      e_a3_d   = A3_D;
      e_we_d   = WE_D;
      e_tnew_d = Tnew_D;
      // Reserved start code 11 behaves as no MDU start.
      e_mds_d  = (MDStart_D == 2'b11) ? MDS_NONE : MDStart_D;
      if (Reset || FlushE) begin
         e_a3_d   = 5'd0;
         e_we_d   = 1'b0;
         e_tnew_d = 2'd0;
         e_mds_d  = MDS_NONE;
      end

      m_a3_d   = e_a3_q;
      m_we_d   = e_we_q;
      m_tnew_d = (e_tnew_q != 2'd0) ? (e_tnew_q - 2'd1) : 2'd0;
      if (Reset) begin
         m_a3_d   = 5'd0;
         m_we_d   = 1'b0;
         m_tnew_d = 2'd0;
      end

      // A new start reloads even if a previous operation is still counting.
      cnt_d = cnt_q;
      if (e_mds_q == MDS_MULT)
         cnt_d = MULT_LD;
      else if (e_mds_q == MDS_DIV)
         cnt_d = DIV_LD;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
      if (Reset)
         cnt_d = '0;
   end

   // State registers; reset is already folded into the _d terms.
   always_ff @(posedge CLK) begin
      e_a3_q   <= e_a3_d;
      e_we_q   <= e_we_d;
      e_tnew_q <= e_tnew_d;
      e_mds_q  <= e_mds_d;
      m_a3_q   <= m_a3_d;
      m_we_q   <= m_we_d;
      m_tnew_q <= m_tnew_d;
      cnt_q    <= cnt_d;
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count stalled edges; wraps naturally at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (Reset)
         stall_cnt_d = 32'd0;
      else if (Stall)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Stall counter register.
   always_ff @(posedge CLK) begin
      stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount = stall_cnt_q;
`endif

endmodule
